// File: rtl/shacc_mult_seq_if.sv
// Handshake bundle for shacc_mult_seq: operand channel (in_*) and product channel (out_*).
// master = operand producer / product consumer, slave = the multiplier.
interface shacc_mult_seq_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_p;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_p
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_p
   );
endinterface

// File: rtl/shacc_mult_seq.sv
// shacc_mult_seq: sequential shift-and-add unsigned multiplier.
// One operand pair is taken in IDLE, one multiplier bit is consumed per RUN
// cycle, and the 2*WIDTH-bit product is held in DONE until the consumer takes it.
// Optional feature macro: SHACC_EARLY_EXIT_EN -- leave RUN as soon as no set
// multiplier bits remain (latency then depends on the MSB of in_b).
module shacc_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   shacc_mult_seq_if.slave   bus,
   output logic              busy
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [2*WIDTH-1:0]   acc_reg, acc_next;
   logic [2*WIDTH-1:0]   sh1_reg, sh1_next;
   logic [WIDTH-1:0]     sh2_reg, sh2_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic [2*WIDTH-1:0]   p_reg, p_next;
   logic                 valid_reg, valid_next;

   logic [2*WIDTH-1:0]   step_acc;
   logic                 last_step;

   // Partial-product add for the current multiplier bit; the 2*WIDTH-bit
   // accumulator can never overflow for WIDTH x WIDTH operands.
   assign step_acc = acc_reg + (sh2_reg[0] ? sh1_reg : '0);

`ifdef SHACC_EARLY_EXIT_EN
   assign last_step = (cnt_reg == CNT_W'(WIDTH - 1)) || ((sh2_reg >> 1) == '0);
`else
   assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));
`endif

   // Operands are only taken in IDLE and never while reset is asserted.
   assign bus.in_ready  = rst_n && (state_reg == IDLE);
   assign bus.out_valid = valid_reg;
   assign bus.out_p     = p_reg;
   assign busy          = (state_reg != IDLE);

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         sh1_reg   <= '0;
         sh2_reg   <= '0;
         cnt_reg   <= '0;
         p_reg     <= '0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         sh1_reg   <= sh1_next;
         sh2_reg   <= sh2_next;
         cnt_reg   <= cnt_next;
         p_reg     <= p_next;
         valid_reg <= valid_next;
      end
   end

   // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      sh1_next   = sh1_reg;
      sh2_next   = sh2_reg;
      cnt_next   = cnt_reg;
      p_next     = p_reg;
      valid_next = valid_reg;

      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               acc_next   = '0;
               sh1_next   = {{WIDTH{1'b0}}, bus.in_a};
               sh2_next   = bus.in_b;
               cnt_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            acc_next = step_acc;
            sh1_next = sh1_reg << 1;
            sh2_next = sh2_reg >> 1;
            cnt_next = cnt_reg + 1'b1;
            if (last_step) begin
               // Publish the accumulator including this cycle's partial product.
               p_next     = step_acc;
               valid_next = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            // Product stays presented until taken; no operand is accepted here.
            if (bus.out_ready) begin
               valid_next = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            valid_next = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shacc_mult_seq.sv
// Testbench for shacc_mult_seq: a driver pushes the arithmetic product and the
// expected latency into a queue at each accept; a monitor pops and checks
// whenever out_valid is presented. Define SHACC_EARLY_EXIT_EN for both RTL and
// bench to check the early-exit latency.
module tb_shacc_mult_seq;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
      int             lat;
      int             acc_cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   logic busy;
   logic ordy;
   logic rand_ordy;
   logic rnd_bit;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   hs_cnt = 0;
   exp_t exp_q[$];

   shacc_mult_seq_if #(.WIDTH(W)) bus ();

   assign bus.out_ready = rand_ordy ? rnd_bit : ordy;

   shacc_mult_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && bus.in_valid && bus.in_ready)
         hs_cnt <= hs_cnt + 1;
   end

   initial begin
      rnd_bit = 1'b1;
      forever begin
         @(negedge clk);
         rnd_bit = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Latency from the accept edge to the edge where out_valid is first seen high.
   function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SHACC_EARLY_EXIT_EN
      int msb = 0;
      for (int i = 0; i < W; i++)
         if (b[i]) msb = i + 1;
      return ((msb < 1) ? 1 : msb) + 1;
`else
      return W + 1;
`endif
   endfunction

   // Monitor: checks every product presented against the scoreboard.
   initial begin
      logic           prev_valid;
      logic [2*W-1:0] held_p;
      exp_t           e;
      prev_valid = 1'b0;
      held_p     = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("busy_vs_in_ready", busy, !bus.in_ready);
            if (bus.out_valid && !prev_valid) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("[TB] FAIL unexpected_out: got out_valid with p=%0d, required no output", bus.out_p);
               end else begin
                  e = exp_q.pop_front();
                  $display("[TB] %0d * %0d -> %0d (expected %0d, latency %0d)",
                           e.a, e.b, bus.out_p, e.p, cyc - e.acc_cyc + 1);
                  check("product", bus.out_p, e.p);
                  check("latency", cyc - e.acc_cyc + 1, e.lat);
               end
               held_p = bus.out_p;
            end else if (bus.out_valid) begin
               check("out_p_hold", bus.out_p, held_p);
            end
            if (bus.out_valid)
               check("no_in_ready_in_done", bus.in_ready, 1'b0);
         end
         prev_valid = bus.out_valid;
      end
   end

   // Present one operand pair and wait for it to be accepted.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
      int   n;
      exp_t e;
      @(negedge clk);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready) begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, required accept", n);
            bus.in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      e.a       = a;
      e.b       = b;
      e.p       = (2*W)'(a) * (2*W)'(b);
      e.lat     = exp_lat(b);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      if (!keep)
         bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 || !bus.in_ready) begin
         @(negedge clk);
         n++;
         if (n > 1000) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
            break;
         end
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!bus.out_valid) begin
         @(negedge clk);
         n++;
         if (n > 100) begin
            tests++;
            fails++;
            $display("[TB] FAIL valid_timeout: got out_valid=0, required 1");
            break;
         end
      end
   endtask

   initial begin
      exp_t dropped;
      int   h0;
      rst_n        = 1'b0;
      ordy         = 1'b1;
      rand_ordy    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready_low", bus.in_ready, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      rst_n = 1'b1;
      #1;
      check("in_ready_after_rst", bus.in_ready, 1'b1);
      @(negedge clk);
      check("rst_out_p", bus.out_p, 0);
      check("rst_busy", busy, 1'b0);

      // Basic product, extremes, zero multiplier and early-exit vectors
      do_op(8'd13, 8'd11, 1'b0);
      wait_drain();
      do_op(8'd255, 8'd255, 1'b0);
      do_op(8'd0, 8'd200, 1'b0);
      do_op(8'd77, 8'd0, 1'b0);
      do_op(8'd200, 8'd1, 1'b0);
      do_op(8'd200, 8'h80, 1'b0);
      wait_drain();

      // Backpressure in DONE for 5 cycles
      ordy = 1'b0;
      do_op(8'd91, 8'd45, 1'b0);
      wait_valid();
      repeat (5) begin
         @(negedge clk);
         check("bp_valid_held", bus.out_valid, 1'b1);
      end
      ordy = 1'b1;
      @(negedge clk);
      check("bp_released", bus.out_valid, 1'b0);
      wait_drain();

      // Reset during RUN cycle 4 aborts the operation
      do_op(8'd100, 8'd200, 1'b0);
      repeat (4) @(negedge clk);
      rst_n   = 1'b0;
      dropped = exp_q.pop_back();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort_in_ready", bus.in_ready, 1'b1);
      check("abort_out_valid", bus.out_valid, 1'b0);
      check("abort_out_p", bus.out_p, 0);
      check("abort_busy", busy, 1'b0);
      repeat (12) @(negedge clk);
      do_op(8'd7, 8'd6, 1'b0);
      wait_drain();

      // in_valid held high across two back-to-back operations
      h0 = hs_cnt;
      do_op(8'd33, 8'd44, 1'b1);
      do_op(8'd250, 8'd3, 1'b0);
      wait_drain();
      check("b2b_accepts", hs_cnt - h0, 2);

      // Randomized operands with random consumer backpressure
      rand_ordy = 1'b1;
      for (int i = 0; i < 24; i++)
         do_op(W'($urandom), W'($urandom), (i != 23) && ($urandom_range(0, 1) == 1));
      wait_drain();
      rand_ordy = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
